alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Handshaked front/back end for the combinational N-bit opcode ALU.
//  Accepts an operand pair on a valid/ready input port and drives it, registered, onto the ALU inputs.
//  Holds the operands stable for SETTLE cycles, captures the ALU result, and presents it on a valid/ready output port.
//  Sits between the operand source (regfile/stimulus) and the result consumer; the ALU is instantiated outside.
// PARAMETERS
//  N       4  operand/result width (bits), >=1
//  SETTLE  1  cycles alu_in0/alu_in1 are held before alu_out is captured, >=1
//  CNT_W   8  width of completed-transaction counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair a/b valid
//  in_ready   out  1      sequencer can accept operands this cycle
//  a          in   N      operand 0
//  b          in   N      operand 1
//  alu_in0    out  N      registered operand 0 to ALU in0
//  alu_in1    out  N      registered operand 1 to ALU in1
//  alu_out    in   N      combinational ALU result
//  res_valid  out  1      res holds a captured result
//  res_ready  in   1      consumer accepts res
//  res        out  N      captured result
//  txn_count  out  CNT_W  completed result handshakes, wraps
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE, alu_in0/alu_in1/res=0, res_valid=0, txn_count=0, settle cnt=0.
//   in_ready is forced 0 while rst_n is low; pending transaction is dropped and not counted.
//  States: IDLE, DRIVE, HOLD (2-bit encoding).
//  in_ready = rst_n & (state==IDLE | (state==HOLD & res_ready)); combinational, no dependency on in_valid.
//  Accept = in_valid & in_ready at an edge: alu_in0<=a, alu_in1<=b, settle cnt<=SETTLE-1, state<=DRIVE.
//  DRIVE: alu_in0/1 held; cnt decrements each edge; on the edge where cnt==0: res<=alu_out, res_valid<=1, ->HOLD.
//  Latency: accept at edge k -> res_valid high after edge k+SETTLE (SETTLE=1: one cycle).
//  HOLD: res and res_valid held stable while res_ready low (no overwrite, no drop).
//   res_valid & res_ready: txn_count<=txn_count+1 (mod 2^CNT_W).
//   If a new accept occurs on the same edge: load operands, ->DRIVE, res_valid<=0.
//   Otherwise: res_valid<=0, ->IDLE. res keeps its last value after handshake.
//  in_valid while not ready: ignored, no state change; a/b may change freely.
//  Arithmetic: sequencer does no math; res is alu_out truncated to N bits as delivered.
//  Illegal state encoding: ->IDLE on next edge, res_valid<=0.
// STRUCTURE
//  alu_defs.vh (shared include): state encodings IDLE/DRIVE/HOLD, ALU opcode constants (ADD=2'b00 ...).
//  Sub-module settle_timer #(SETTLE): load/decrement counter, outputs done when count==0; the rest stays in the top module.
// TESTING  (N=4, SETTLE=1, ALU OPCODE=2'b00 add, res_ready=1 unless stated)
//  1 a=4'b0011,b=4'b0101, accept at edge k -> alu_in0=0011/alu_in1=0101 after k; res=4'b1000,res_valid after k+1; txn_count=1.
//  2 a=4'b1111,b=4'b0001 -> res=4'b0000 (carry dropped); res_valid for exactly 1 cycle with res_ready=1.
//  3 Backpressure: res_ready=0 for 5 cycles after result -> res/res_valid stable, in_ready=0, in_valid ignored.
//  4 Back-to-back: res_ready=1 in HOLD with in_valid=1 (a=2,b=3) -> same-edge accept, next res=4'b0101, no idle cycle.
//  5 Reset in DRIVE (SETTLE=3, rst_n low 1 cycle) -> all outputs 0 immediately, txn_count unchanged at 0, IDLE.
//  6 SETTLE=3: accept at edge k -> res_valid after k+3; 256 transactions -> txn_count wraps to 0.

Source files
------------

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encoding,
// ALU opcode encoding and a counter-width helper.
package alu_operand_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_HOLD  = 2'b10
    } state_e;

    // Opcode encoding of the external combinational ALU.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    // A settle count of 1 still needs a 1-bit register to hold the value 0.
    function automatic int unsigned cnt_width(input int unsigned settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_settle_timer.sv
// Settle timer: loads SETTLE-1 when operands are accepted, counts down while
// enabled and flags done when the count reaches zero.
module alu_operand_sequencer_settle_timer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic done_o
);

    localparam int unsigned CW = cnt_width(SETTLE);
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_operand_sequencer.sv
// Handshaked front/back end for an external combinational ALU: registers an
// operand pair, holds it for SETTLE cycles, captures the result and offers it.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [N-1:0]     alu_in0,
    output logic [N-1:0]     alu_in1,
    input  logic [N-1:0]     alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res,
    output logic [CNT_W-1:0] txn_count
);

    state_e           state_q,     state_d;
    logic [N-1:0]     alu_in0_q,   alu_in0_d;
    logic [N-1:0]     alu_in1_q,   alu_in1_d;
    logic [N-1:0]     res_q,       res_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] txn_q,       txn_d;

    logic accept;
    logic settle_done;

    // Ready never looks at in_valid, so no combinational loop through the source.
    assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & res_ready));
    assign accept   = in_valid & in_ready;

    alu_operand_sequencer_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .dec_i  (state_q == ST_DRIVE),
        .done_o (settle_done)
    );

    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves it unassigned and infers a latch.
    always_comb begin
        state_d     = state_q;
        alu_in0_d   = alu_in0_q;
        alu_in1_d   = alu_in1_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        txn_d       = txn_q;

        if (accept) begin
            alu_in0_d = a;
            alu_in1_d = b;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (settle_done) begin
                    res_d       = alu_out;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    txn_d       = txn_q + 1'b1;
                    res_valid_d = 1'b0;
                    state_d     = accept ? ST_DRIVE : ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_in0_q   <= '0;
            alu_in1_q   <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            txn_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_in0_q   <= alu_in0_d;
            alu_in1_q   <= alu_in1_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            txn_q       <= txn_d;
        end
    end

    assign alu_in0   = alu_in0_q;
    assign alu_in1   = alu_in1_q;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign txn_count = txn_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer: two instances (SETTLE=1 and 3)
// driven by directed and random traffic, checked against a transaction model.
module tb_alu_operand_sequencer;
    import alu_operand_sequencer_pkg::*;

    localparam int N           = 4;
    localparam int CNT_W       = 8;
    localparam int S0          = 1;
    localparam int S1          = 3;
    localparam int RAND_CYCLES = 4000;

    typedef struct packed {
        logic [N-1:0] res;
        logic [31:0]  cyc;
    } exp_t;

    logic             clk;
    logic             rst_n     [2];
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic [N-1:0]     a         [2];
    logic [N-1:0]     b         [2];
    logic [N-1:0]     alu_in0   [2];
    logic [N-1:0]     alu_in1   [2];
    logic [N-1:0]     alu_out   [2];
    logic             res_valid [2];
    logic             res_ready [2];
    logic [N-1:0]     res       [2];
    logic [CNT_W-1:0] txn_count [2];

    int n_cmp;
    int n_err;
    int hs_total [2];
    bit drv_done [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] alu_model(input alu_op_e op, input logic [N-1:0] x,
                                               input logic [N-1:0] y);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_AND:  return x & y;
            default: return x ^ y;
        endcase
    endfunction

    assign alu_out[0] = alu_model(OP_ADD, alu_in0[0], alu_in1[0]);
    assign alu_out[1] = alu_model(OP_ADD, alu_in0[1], alu_in1[1]);

    alu_operand_sequencer #(.N(N), .SETTLE(S0), .CNT_W(CNT_W)) u_dut_s1 (
        .clk       (clk),
        .rst_n     (rst_n[0]),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .a         (a[0]),
        .b         (b[0]),
        .alu_in0   (alu_in0[0]),
        .alu_in1   (alu_in1[0]),
        .alu_out   (alu_out[0]),
        .res_valid (res_valid[0]),
        .res_ready (res_ready[0]),
        .res       (res[0]),
        .txn_count (txn_count[0])
    );

    alu_operand_sequencer #(.N(N), .SETTLE(S1), .CNT_W(CNT_W)) u_dut_s3 (
        .clk       (clk),
        .rst_n     (rst_n[1]),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .a         (a[1]),
        .b         (b[1]),
        .alu_in0   (alu_in0[1]),
        .alu_in1   (alu_in1[1]),
        .alu_out   (alu_out[1]),
        .res_valid (res_valid[1]),
        .res_ready (res_ready[1]),
        .res       (res[1]),
        .txn_count (txn_count[1])
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL [dut%0d] %s: got 0x%0h, expected 0x%0h at %0t", idx, name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each accepted pair becomes one expected result,
    // visible SETTLE edges after acceptance and held until the consumer takes it.
    task automatic monitor(input int idx, input int settle);
        exp_t             q[$];
        exp_t             e;
        int               cyc       = 0;
        logic [N-1:0]     last_res  = '0;
        logic [N-1:0]     last_a    = '0;
        logic [N-1:0]     last_b    = '0;
        logic [CNT_W-1:0] model_cnt = '0;
        logic [N-1:0]     exp_res;
        logic [N-1:0]     sum;
        bit               exp_valid;
        bit               exp_rdy;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (!rst_n[idx]) begin
                q.delete();
                last_res  = '0;
                last_a    = '0;
                last_b    = '0;
                model_cnt = '0;
                continue;
            end
            exp_valid = (q.size() > 0) && ((cyc - int'(q[0].cyc)) >= settle + 1);
            exp_res   = exp_valid ? q[0].res : last_res;
            exp_rdy   = (q.size() == 0) || (exp_valid && res_ready[idx]);

            check("res_valid", idx, 32'(res_valid[idx]), 32'(exp_valid));
            check("res", idx, 32'(res[idx]), 32'(exp_res));
            check("in_ready", idx, 32'(in_ready[idx]), 32'(exp_rdy));
            check("alu_in0", idx, 32'(alu_in0[idx]), 32'(last_a));
            check("alu_in1", idx, 32'(alu_in1[idx]), 32'(last_b));
            check("txn_count", idx, 32'(txn_count[idx]), 32'(model_cnt));

            if (exp_valid && res_ready[idx]) begin
                e         = q.pop_front();
                last_res  = e.res;
                model_cnt = model_cnt + 1'b1;
                hs_total[idx]++;
            end
            if (exp_rdy && in_valid[idx]) begin
                sum   = a[idx] + b[idx];
                e.res = sum;
                e.cyc = cyc;
                q.push_back(e);
                last_a = a[idx];
                last_b = b[idx];
            end
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge, with in_valid dropped.
    task automatic send(input int idx, input logic [N-1:0] av, input logic [N-1:0] bv);
        int waited = 0;
        in_valid[idx] = 1'b1;
        a[idx]        = av;
        b[idx]        = bv;
        forever begin
            #4;
            if (in_ready[idx]) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                check("send_timeout_in_ready", idx, 32'(in_ready[idx]), 32'd1);
                break;
            end
        end
        in_valid[idx] = 1'b0;
    endtask

    task automatic drive(input int idx, input int settle);
        in_valid[idx]  = 1'b0;
        res_ready[idx] = 1'b1;
        a[idx]         = '0;
        b[idx]         = '0;
        rst_n[idx]     = 1'b0;
        repeat (3) @(negedge clk);
        rst_n[idx] = 1'b1;
        @(negedge clk);

        if (idx == 1) begin
            send(idx, 4'd9, 4'd4);
            #2 rst_n[idx] = 1'b0;
            #1;
            check("rst_res_valid", idx, 32'(res_valid[idx]), 32'd0);
            check("rst_res", idx, 32'(res[idx]), 32'd0);
            check("rst_alu_in0", idx, 32'(alu_in0[idx]), 32'd0);
            check("rst_alu_in1", idx, 32'(alu_in1[idx]), 32'd0);
            check("rst_in_ready", idx, 32'(in_ready[idx]), 32'd0);
            check("rst_txn_count", idx, 32'(txn_count[idx]), 32'd0);
            @(negedge clk);
            #2 rst_n[idx] = 1'b1;
            @(negedge clk);
        end

        send(idx, 4'b0011, 4'b0101);
        send(idx, 4'b1111, 4'b0001);
        repeat (settle + 2) @(negedge clk);

        res_ready[idx] = 1'b0;
        send(idx, 4'd6, 4'd7);
        repeat (settle + 6) begin
            in_valid[idx] = 1'b1;
            a[idx]        = N'($urandom);
            b[idx]        = N'($urandom);
            @(negedge clk);
        end
        res_ready[idx] = 1'b1;
        send(idx, 4'd2, 4'd3);
        send(idx, 4'd4, 4'd4);

        for (int c = 0; c < RAND_CYCLES; c++) begin
            in_valid[idx]  = 1'($urandom_range(0, 1));
            a[idx]         = N'($urandom);
            b[idx]         = N'($urandom);
            res_ready[idx] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid[idx]  = 1'b0;
        res_ready[idx] = 1'b1;
        repeat (settle + 4) @(negedge clk);
        drv_done[idx] = 1'b1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        hs_total[0] = 0;
        hs_total[1] = 0;
        drv_done[0] = 1'b0;
        drv_done[1] = 1'b0;
        fork
            monitor(0, S0);
            monitor(1, S1);
            drive(0, S0);
            drive(1, S1);
        join_none

        for (int g = 0; g < 20000 && !(drv_done[0] && drv_done[1]); g++) begin
            @(negedge clk);
        end
        check("drivers_done", 0, 32'(drv_done[0] & drv_done[1]), 32'd1);
        check("txn_wrap_reached", 1, 32'(hs_total[1] > 256), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
